// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC pipeline: fetch FSM states,
// opcode groups and the default memory vector locations.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        IMM,
        IVEC
    } fetch_state_t;

    localparam logic [3:0] OP_IMM_GRP          = 4'hC;
    localparam logic [7:0] DEF_RESET_VEC_ADDR  = 8'h00;
    localparam logic [7:0] DEF_INTR_VEC_ADDR   = 8'h01;

    // LDM/LDD/STD carry a second byte holding an immediate or address.
    function automatic logic is_two_byte(input logic [7:0] opcode);
        return opcode[7:4] == OP_IMM_GRP;
    endfunction

endpackage

// File: rtl/fetch_unit_intr_latch.sv
// Interrupt request edge detector with pending and in-handler flags.
// No nesting: edges seen while a handler is active are dropped.
module intr_latch (
    input  logic clk,
    input  logic reset,
    input  logic interrupt,
    input  logic take,
    input  logic intr_ret,
    output logic intr_pend,
    output logic intr_active
);

    logic int_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_d       <= 1'b0;
            intr_pend   <= 1'b0;
            intr_active <= 1'b0;
        end else begin
            int_d <= interrupt;

            if (take)
                intr_pend <= 1'b0;
            else if (interrupt && !int_d && !intr_active)
                intr_pend <= 1'b1;

            if (take)
                intr_active <= 1'b1;
            else if (intr_ret)
                intr_active <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, boot vector load, two-byte
// instruction assembly, EX branch redirect and interrupt entry.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_VEC_ADDR = DEF_RESET_VEC_ADDR,
    parameter logic [7:0] INTR_VEC_ADDR  = DEF_INTR_VEC_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       f_stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       interrupt,
    input  logic       intr_ret,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] instr,
    output logic [7:0] immediate,
    output logic       imm_valid,
    output logic       f_valid,
    output logic [7:0] pc,
    output logic [7:0] ret_pc,
    output logic       intr_ack,
    output logic       intr_active
);

    fetch_state_t state;
    logic [7:0]   fetch_pc;
    logic [7:0]   op_hold;
    logic         intr_pend;
    logic         take;

    intr_latch u_intr_latch (
        .clk         (clk),
        .reset       (reset),
        .interrupt   (interrupt),
        .take        (take),
        .intr_ret    (intr_ret),
        .intr_pend   (intr_pend),
        .intr_active (intr_active)
    );

    // Interrupts are only entered on an instruction boundary.
    assign take     = (state == RUN) && intr_pend && !f_stall && !branch_taken;
    assign intr_ack = take;
    assign ret_pc   = pc;

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        imem_addr = fetch_pc;
        instr     = 8'h00;
        immediate = 8'h00;
        imm_valid = 1'b0;
        f_valid   = 1'b0;
        case (state)
            BOOT: imem_addr = RESET_VEC_ADDR;
            RUN: begin
                instr   = imem_data;
                f_valid = !is_two_byte(imem_data) && !branch_taken && !take;
            end
            IMM: begin
                instr     = op_hold;
                immediate = imem_data;
                imm_valid = 1'b1;
                f_valid   = !branch_taken;
            end
            IVEC: imem_addr = INTR_VEC_ADDR;
            default: ;
        endcase
    end

    // fetch_pc walks every byte; pc stays on the first byte of the instruction.
    // NOTE: all state registers, op_hold included, take a defined value on
    // reset so the first fetch after reset never sees X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            fetch_pc <= 8'h00;
            pc       <= 8'h00;
            op_hold  <= 8'h00;
        end else if (state == BOOT) begin
            fetch_pc <= imem_data;
            pc       <= imem_data;
            state    <= RUN;
        end else if (branch_taken) begin
            fetch_pc <= branch_target;
            pc       <= branch_target;
            state    <= RUN;
        end else if (state == IVEC) begin
            fetch_pc <= imem_data;
            pc       <= imem_data;
            state    <= RUN;
        end else if (!f_stall) begin
            if (take) begin
                state <= IVEC;
            end else if (state == IMM) begin
                fetch_pc <= fetch_pc + 8'd1;
                pc       <= fetch_pc + 8'd1;
                state    <= RUN;
            end else if (is_two_byte(imem_data)) begin
                op_hold  <= imem_data;
                fetch_pc <= fetch_pc + 8'd1;
                state    <= IMM;
            end else begin
                fetch_pc <= fetch_pc + 8'd1;
                pc       <= fetch_pc + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       f_stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       interrupt;
    logic       intr_ret;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic [7:0] immediate;
    logic       imm_valid;
    logic       f_valid;
    logic [7:0] pc;
    logic [7:0] ret_pc;
    logic       intr_ack;
    logic       intr_active;

    logic [7:0] mem [256];

    typedef struct packed {
        logic       fv;
        logic       iv;
        logic       ack;
        logic       act;
        logic [7:0] pc;
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] addr;
    } obs_t;

    typedef struct {
        string      tag;
        obs_t       o;
        logic [7:0] ret;
    } exp_t;

    exp_t sb[$];
    obs_t obs;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];
    assign obs = {f_valid, imm_valid, intr_ack, intr_active, pc, instr, immediate, imem_addr};

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .f_stall       (f_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .interrupt     (interrupt),
        .intr_ret      (intr_ret),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr         (instr),
        .immediate     (immediate),
        .imm_valid     (imm_valid),
        .f_valid       (f_valid),
        .pc            (pc),
        .ret_pc        (ret_pc),
        .intr_ack      (intr_ack),
        .intr_active   (intr_active)
    );

    task automatic expect_out(input string tag, input logic fv, input logic iv,
                              input logic ack, input logic act, input logic [7:0] p,
                              input logic [7:0] ins, input logic [7:0] imm,
                              input logic [7:0] addr, input logic [7:0] ret);
        exp_t e;
        e.tag = tag;
        e.o   = {fv, iv, ack, act, p, ins, imm, addr};
        e.ret = ret;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: observed empty queue, required an entry");
        end else begin
            e = sb.pop_front();
            n_tests++;
            assert (obs === e.o) else begin
                n_fail++;
                $error("FAIL %s: observed fv=%b iv=%b ack=%b act=%b pc=%h instr=%h imm=%h addr=%h, expected fv=%b iv=%b ack=%b act=%b pc=%h instr=%h imm=%h addr=%h",
                       e.tag, obs.fv, obs.iv, obs.ack, obs.act, obs.pc, obs.instr, obs.imm, obs.addr,
                       e.o.fv, e.o.iv, e.o.ack, e.o.act, e.o.pc, e.o.instr, e.o.imm, e.o.addr);
            end
            if (e.o.ack) begin
                n_tests++;
                assert (ret_pc === e.ret) else begin
                    n_fail++;
                    $error("FAIL %s_ret_pc: observed %h expected %h", e.tag, ret_pc, e.ret);
                end
            end
        end
    endtask

    task automatic tick();
        sample();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h30 + 8'(i % 16);
        mem[8'h00] = 8'h10;
        mem[8'h01] = 8'h80;
        mem[8'h10] = 8'h01;
        mem[8'h11] = 8'hC1;
        mem[8'h12] = 8'h5A;
        mem[8'h13] = 8'hC2;
        mem[8'h14] = 8'h77;
        mem[8'h40] = 8'h42;
        mem[8'hFF] = 8'h03;

        reset = 1'b1; f_stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        interrupt = 1'b0; intr_ret = 1'b0;
        @(negedge clk);

        // Reset and boot vector load
        expect_out("reset",          0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        reset = 1'b0;
        expect_out("boot",           0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        expect_out("run_single",     1,0,0,0, 8'h10, 8'h01, 8'h00, 8'h10, 8'h00); tick();

        // Two-byte instruction with a stall held across its immediate cycle
        expect_out("two_byte_first", 0,0,0,0, 8'h11, 8'hC1, 8'h00, 8'h11, 8'h00); tick();
        f_stall = 1'b1;
        expect_out("imm_stall_1",    1,1,0,0, 8'h11, 8'hC1, 8'h5A, 8'h12, 8'h00); tick();
        expect_out("imm_stall_2",    1,1,0,0, 8'h11, 8'hC1, 8'h5A, 8'h12, 8'h00); tick();
        expect_out("imm_stall_3",    1,1,0,0, 8'h11, 8'hC1, 8'h5A, 8'h12, 8'h00); tick();
        f_stall = 1'b0;
        expect_out("imm_resume",     1,1,0,0, 8'h11, 8'hC1, 8'h5A, 8'h12, 8'h00); tick();

        // Branch during IMM wins over a simultaneous stall
        expect_out("two_byte_2",     0,0,0,0, 8'h13, 8'hC2, 8'h00, 8'h13, 8'h00); tick();
        branch_taken = 1'b1; branch_target = 8'h40; f_stall = 1'b1;
        expect_out("imm_branch",     0,1,0,0, 8'h13, 8'hC2, 8'h77, 8'h14, 8'h00); tick();
        branch_taken = 1'b0; f_stall = 1'b0;
        expect_out("after_branch",   1,0,0,0, 8'h40, 8'h42, 8'h00, 8'h40, 8'h00); tick();

        // Interrupt edge arrives with a branch to 0x20; entry at that boundary
        branch_taken = 1'b1; branch_target = 8'h20; interrupt = 1'b1;
        expect_out("branch_intr",    0,0,0,0, 8'h41, 8'h31, 8'h00, 8'h41, 8'h00); tick();
        branch_taken = 1'b0; interrupt = 1'b0;
        expect_out("intr_entry",     0,0,1,0, 8'h20, 8'h30, 8'h00, 8'h20, 8'h20); tick();
        interrupt = 1'b1;
        expect_out("ivec",           0,0,0,1, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00); tick();
        interrupt = 1'b0;
        expect_out("handler",        1,0,0,1, 8'h80, 8'h30, 8'h00, 8'h80, 8'h00); tick();
        intr_ret = 1'b1;
        expect_out("no_nest",        1,0,0,1, 8'h81, 8'h31, 8'h00, 8'h81, 8'h00); tick();
        intr_ret = 1'b0; branch_taken = 1'b1; branch_target = 8'hFF;
        expect_out("intr_cleared",   0,0,0,0, 8'h82, 8'h32, 8'h00, 8'h82, 8'h00); tick();
        branch_taken = 1'b0;

        // PC wrap, then a second interrupt interrupted by reset in IVEC
        expect_out("wrap_ff",        1,0,0,0, 8'hFF, 8'h03, 8'h00, 8'hFF, 8'h00); tick();
        interrupt = 1'b1;
        expect_out("wrap_00",        1,0,0,0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00); tick();
        interrupt = 1'b0;
        expect_out("intr2_entry",    0,0,1,0, 8'h01, 8'h80, 8'h00, 8'h01, 8'h01); tick();
        expect_out("ivec2",          0,0,0,1, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00); sample();
        #1 reset = 1'b1;
        expect_out("reset_async",    0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); sample();
        @(negedge clk);
        expect_out("reset_hold",     0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        reset = 1'b0;
        expect_out("reboot",         0,0,0,0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); tick();
        expect_out("reboot_run",     1,0,0,0, 8'h10, 8'h01, 8'h00, 8'h10, 8'h00); tick();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: observed %0d entries left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
